decode_queue: RTL

Parametrised instruction queue and decoder between instruction fetch and dispatch. Fetch pushes (pc, inst, predict) tuples into a DEPTH-entry circular buffer. The head entry is decoded combinationally and issued to ROB plus RS or LSB when the targets have room. Fetch and dispatch are decoupled, and the whole queue is squashed on ROB flush.

---
 rtl/decode_queue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// decode_queue: circular instruction buffer between fetch and dispatch.
// The head entry is decoded combinationally and issued to the ROB plus
// either the RS or the LSB when those targets have room.
module decode_queue #(
    parameter int DEPTH      = 8,
    parameter int AFULL      = DEPTH - 2,
    parameter int REG_ID_BIT = 5
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       in_predict,
    output logic                       in_ready,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       rob_full,
    input  logic                       rs_full,
    input  logic                       lsb_full,
    output logic                       to_rob,
    output logic                       to_rs,
    output logic                       to_lsb,
    output logic [5:0]                 op_type,
    output logic [REG_ID_BIT-1:0]      rs1,
    output logic [REG_ID_BIT-1:0]      rs2,
    output logic [REG_ID_BIT-1:0]      dest,
    output logic [31:0]                imm,
    output logic [31:0]                inst_pc,
    output logic                       guess
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue storage: data only, never reset
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic        pred_q [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]        head_inst;
    logic [5:0]         op_dec;
    logic signed [31:0] imm_dec;
    logic               is_mem;
    logic               enq;
    logic               issue;

    // Map opcode/func3/func7 to the op_type encoding; exit word wins over addi
    function automatic logic [5:0] decode_op(input logic [31:0] i);
        logic [5:0] op;
        op = 6'd39;
        if (i == 32'h0ff00513) begin
            op = 6'd38;
        end else begin
            case (i[6:0])
                7'b0110111: op = 6'd0;
                7'b0010111: op = 6'd1;
                7'b1101111: op = 6'd2;
                7'b1100111: op = (i[14:12] == 3'b000) ? 6'd3 : 6'd39;
                7'b1100011: begin
                    case (i[14:12])
                        3'b000:  op = 6'd4;
                        3'b001:  op = 6'd5;
                        3'b100:  op = 6'd6;
                        3'b101:  op = 6'd7;
                        3'b110:  op = 6'd8;
                        3'b111:  op = 6'd9;
                        default: op = 6'd39;
                    endcase
                end
                7'b0000011: begin
                    case (i[14:12])
                        3'b000:  op = 6'd10;
                        3'b001:  op = 6'd11;
                        3'b010:  op = 6'd12;
                        3'b100:  op = 6'd13;
                        3'b101:  op = 6'd14;
                        default: op = 6'd39;
                    endcase
                end
                7'b0100011: begin
                    case (i[14:12])
                        3'b000:  op = 6'd15;
                        3'b001:  op = 6'd16;
                        3'b010:  op = 6'd17;
                        default: op = 6'd39;
                    endcase
                end
                7'b0010011: begin
                    case (i[14:12])
                        3'b000:  op = 6'd18;
                        3'b010:  op = 6'd19;
                        3'b011:  op = 6'd20;
                        3'b100:  op = 6'd21;
                        3'b110:  op = 6'd22;
                        3'b111:  op = 6'd23;
                        3'b001:  op = 6'd24;
                        default: op = i[30] ? 6'd26 : 6'd25;
                    endcase
                end
                7'b0110011: begin
                    case (i[14:12])
                        3'b000:  op = i[30] ? 6'd28 : 6'd27;
                        3'b001:  op = 6'd29;
                        3'b010:  op = 6'd30;
                        3'b011:  op = 6'd31;
                        3'b100:  op = 6'd32;
                        3'b101:  op = i[30] ? 6'd34 : 6'd33;
                        3'b110:  op = 6'd35;
                        default: op = 6'd36;
                    endcase
                end
                default: op = 6'd39;
            endcase
        end
        return op;
    endfunction

    // Immediate selection by instruction format
    function automatic logic signed [31:0] decode_imm(input logic [31:0] i,
                                                     input logic [31:0] pc,
                                                     input logic [5:0]  op);
        logic signed [31:0] v;
        v = '0;
        if (op == 6'd0)
            v = {i[31:12], 12'b0};
        else if (op == 6'd1)
            v = pc + {i[31:12], 12'b0};
        else if (op == 6'd2)
            v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        else if (op == 6'd3 || (op >= 6'd10 && op <= 6'd14) || (op >= 6'd18 && op <= 6'd23))
            v = {{20{i[31]}}, i[31:20]};
        else if (op >= 6'd24 && op <= 6'd26)
            v = {27'b0, i[24:20]};
        else if (op >= 6'd4 && op <= 6'd9)
            v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        else if (op >= 6'd15 && op <= 6'd17)
            v = {{20{i[31]}}, i[31:25], i[11:7]};
        return v;
    endfunction

    // Head decode, operand masking and issue routing
    always_comb begin
        head_inst = inst_q[head_q];
        op_dec    = decode_op(head_inst);
        imm_dec   = decode_imm(head_inst, pc_q[head_q], op_dec);
        is_mem    = (op_dec >= 6'd10) && (op_dec <= 6'd17);
        op_type   = op_dec;
        imm       = imm_dec;
        inst_pc   = pc_q[head_q];
        guess     = pred_q[head_q];
        rs1       = '0;
        rs2       = '0;
        dest      = '0;
        if (op_dec >= 6'd3 && op_dec <= 6'd36)
            rs1 = head_inst[19:15];
        if ((op_dec >= 6'd4 && op_dec <= 6'd9) || (op_dec >= 6'd15 && op_dec <= 6'd17) ||
            (op_dec >= 6'd27 && op_dec <= 6'd36))
            rs2 = head_inst[24:20];
        if (!((op_dec >= 6'd4 && op_dec <= 6'd9) || (op_dec >= 6'd15 && op_dec <= 6'd17) ||
              (op_dec >= 6'd37)))
            dest = head_inst[11:7];
    end

    assign in_ready    = (count_q < CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AFULL));
    assign count       = count_q;

    assign issue  = !rst_in && rdy_in && !flush_in && (count_q != '0) && !rob_full &&
                    (is_mem ? !lsb_full : !rs_full);
    assign enq    = rdy_in && in_valid && in_ready && !flush_in;
    assign to_rob = issue;
    assign to_lsb = issue && is_mem;
    assign to_rs  = issue && !is_mem;

    // Pointer and occupancy next state; flush squashes everything
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq)
                tail_d = tail_q + PW'(1);
            if (issue)
                head_d = head_q + PW'(1);
            if (enq && !issue)
                count_d = count_q + CW'(1);
            else if (!enq && issue)
                count_d = count_q - CW'(1);
        end
    end

    // Control registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at tail
    always_ff @(posedge clk_in) begin
        if (enq && !rst_in) begin
            pc_q[tail_q]   <= in_pc;
            inst_q[tail_q] <= in_inst;
            pred_q[tail_q] <= in_predict;
        end
    end
endmodule
